// File: rtl/sreg_deser_pkg.sv
// Shared definitions for the serial-to-parallel deserialiser.
//   clog2_min1  : ceil(log2(n)) floored at 1, for counter and pointer widths
//   bit_order_e : symbolic names for the two bit orders
package sreg_deser_pkg;

  typedef enum logic {
    BIT_LSB_FIRST = 1'b0,
    BIT_MSB_FIRST = 1'b1
  } bit_order_e;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sreg_deser_stream_sync_fifo.sv
// Synchronous FIFO with first-word fall-through output.
//   clk, rst   : clock, synchronous active-high reset (pointers only)
//   push, din  : write request and data; accepted when not full, or when
//                full and a pop happens on the same edge
//   pop        : remove head word; ignored when empty
//   dout       : head word, reads as zero while empty
//   full/empty : occupancy flags
module sync_fifo
  import sreg_deser_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2_min1(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // When full with a simultaneous pop, the write lands in the slot being
  // vacated; the old head has already been consumed through dout.
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sreg_deser_stream.sv
// Serial-to-parallel deserialiser with a buffered valid/ready word output.
//   clk, rst      : clock, synchronous active-high reset
//   serial_in     : serial data bit, sampled when serial_valid=1
//   serial_valid  : qualifies serial_in on this edge
//   align         : restarts word framing; discards the bit on this edge
//   out_data      : head word of the output buffer (zero when empty)
//   out_valid     : out_data holds a word
//   out_ready     : consumer accepts out_data when out_valid & out_ready
//   overflow      : sticky flag, a completed word was dropped
//   drop_count    : saturating count of dropped words
//   bit_idx       : bits already collected in the current partial word
module sreg_deser_stream
  import sreg_deser_pkg::*;
#(
  parameter int WORD_W     = 8,
  parameter int LSB_FIRST  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          serial_in,
  input  logic                          serial_valid,
  input  logic                          align,
  output logic [WORD_W-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          overflow,
  output logic [CNT_W-1:0]              drop_count,
  output logic [clog2_min1(WORD_W)-1:0] bit_idx
);

  localparam int BI_W = clog2_min1(WORD_W);

  logic [WORD_W-1:0] sr;
  logic [WORD_W-1:0] sr_shift;
  logic              last_bit;
  logic              word_done;
  logic              pop;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;

  always_comb begin
    if (LSB_FIRST != 0) sr_shift = {serial_in, sr[WORD_W-1:1]};
    else                sr_shift = {sr[WORD_W-2:0], serial_in};
  end

  assign last_bit  = (bit_idx == BI_W'(WORD_W - 1));
  // align suppresses completion even on the final bit of a word.
  assign word_done = serial_valid && !align && last_bit;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  // A full buffer still takes the word if a pop frees a slot on this edge.
  assign drop      = word_done && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx    <= '0;
      sr         <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (align) begin
        bit_idx <= '0;
        sr      <= '0;
      end else if (serial_valid) begin
        sr      <= sr_shift;
        bit_idx <= last_bit ? '0 : bit_idx + 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != {CNT_W{1'b1}}) drop_count <= drop_count + 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (word_done),
    .din   (sr_shift),
    .pop   (pop),
    .dout  (out_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_sreg_deser_stream.sv
module tb_sreg_deser_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic serial_in = 1'b0;
  logic serial_valid = 1'b0;
  logic align = 1'b0;
  logic out_ready = 1'b0;

  // a: LSB first, CNT_W=8; m: MSB first; s: CNT_W=2
  logic [7:0] a_data, m_data, s_data;
  logic       a_valid, m_valid, s_valid;
  logic       a_ovf, m_ovf, s_ovf;
  logic [7:0] a_cnt, m_cnt;
  logic [1:0] s_cnt;
  logic [2:0] a_idx, m_idx, s_idx;

  sreg_deser_stream #(.WORD_W(8), .LSB_FIRST(1), .FIFO_DEPTH(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .serial_in(serial_in), .serial_valid(serial_valid),
    .align(align), .out_data(a_data), .out_valid(a_valid), .out_ready(out_ready),
    .overflow(a_ovf), .drop_count(a_cnt), .bit_idx(a_idx));

  sreg_deser_stream #(.WORD_W(8), .LSB_FIRST(0), .FIFO_DEPTH(4), .CNT_W(8)) dut_m (
    .clk(clk), .rst(rst), .serial_in(serial_in), .serial_valid(serial_valid),
    .align(align), .out_data(m_data), .out_valid(m_valid), .out_ready(out_ready),
    .overflow(m_ovf), .drop_count(m_cnt), .bit_idx(m_idx));

  sreg_deser_stream #(.WORD_W(8), .LSB_FIRST(1), .FIFO_DEPTH(4), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .serial_in(serial_in), .serial_valid(serial_valid),
    .align(align), .out_data(s_data), .out_valid(s_valid), .out_ready(out_ready),
    .overflow(s_ovf), .drop_count(s_cnt), .bit_idx(s_idx));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    serial_in    = b;
    serial_valid = 1'b1;
    tick();
    serial_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) send_bit(w[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    serial_valid = 1'b0;
    align = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  logic [31:0] stream;
  logic [7:0]  exp_lsb [4];
  logic [7:0]  exp_msb [4];
  logic [7:0]  fill    [4];
  logic [7:0]  w55;

  initial begin
    stream  = 32'hABCD1234;
    exp_lsb = '{8'h34, 8'h12, 8'hCD, 8'hAB};
    exp_msb = '{8'hAB, 8'hCD, 8'h12, 8'h34};
    fill    = '{8'h11, 8'h22, 8'h33, 8'h44};
    w55     = 8'h55;

    tick();
    do_reset();
    chk("rst bit_idx", a_idx, 0);
    chk("rst out_valid", a_valid, 0);
    chk("rst out_data", a_data, 0);
    chk("rst overflow", a_ovf, 0);
    chk("rst drop_count", a_cnt, 0);

    // T1: LSB first, always ready, one-cycle valid pulses
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      serial_in = stream[i];
      serial_valid = 1'b1;
      tick();
      chk($sformatf("t1 valid b%0d", i), a_valid, (i % 8 == 7));
      if (i % 8 == 7) chk($sformatf("t1 data w%0d", i / 8), a_data, exp_lsb[i / 8]);
    end
    serial_valid = 1'b0;
    tick();
    chk("t1 idle valid", a_valid, 0);

    // T2: MSB first
    do_reset();
    for (int i = 0; i < 32; i++) begin
      serial_in = stream[31 - i];
      serial_valid = 1'b1;
      tick();
      if (i % 8 == 7) begin
        chk($sformatf("t2 valid w%0d", i / 8), m_valid, 1);
        chk($sformatf("t2 data w%0d", i / 8), m_data, exp_msb[i / 8]);
      end
    end
    serial_valid = 1'b0;

    // T3: backpressure and overflow
    do_reset();
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) send_word(8'(k));
    chk("t3 overflow", a_ovf, 1);
    chk("t3 drop_count", a_cnt, 1);
    chk("t3 held valid", a_valid, 1);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("t3 drain %0d", k), a_data, k);
      tick();
    end
    chk("t3 drained empty", a_valid, 0);
    chk("t3 overflow sticky", a_ovf, 1);
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send_word(fill[k]);
    for (int i = 0; i < 7; i++) send_bit(w55[i]);
    serial_in = w55[7];
    serial_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    serial_valid = 1'b0;
    out_ready = 1'b0;
    chk("t3 push+pop count", a_cnt, 1);
    chk("t3 push+pop head", a_data, 8'h22);
    out_ready = 1'b1;
    chk("t3 pp drain 22", a_data, 8'h22); tick();
    chk("t3 pp drain 33", a_data, 8'h33); tick();
    chk("t3 pp drain 44", a_data, 8'h44); tick();
    chk("t3 pp drain 55", a_data, 8'h55); tick();
    chk("t3 pp empty", a_valid, 0);

    // T4: align restarts framing, queued word survives
    do_reset();
    out_ready = 1'b0;
    send_word(8'h5A);
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
    chk("t4 idx before align", a_idx, 3);
    align = 1'b1;
    serial_in = 1'b1;
    serial_valid = 1'b1;
    tick();
    align = 1'b0;
    serial_valid = 1'b0;
    chk("t4 idx after align", a_idx, 0);
    chk("t4 queued kept", a_data, 8'h5A);
    send_word(8'hA5);
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    align = 1'b1;
    serial_in = 1'b1;
    serial_valid = 1'b1;
    tick();
    align = 1'b0;
    serial_valid = 1'b0;
    chk("t4 align at last bit idx", a_idx, 0);
    out_ready = 1'b1;
    chk("t4 word 5A", a_data, 8'h5A); tick();
    chk("t4 word A5", a_data, 8'hA5); tick();
    chk("t4 no extra word", a_valid, 0);

    // T5: gapped input, then mid-word reset
    for (int i = 0; i < 8; i++) begin
      serial_in = (8'h3C >> i) & 1'b1;
      serial_valid = 1'b1;
      tick();
      serial_valid = 1'b0;
      serial_in = ~serial_in;
      tick();
      if (i == 3) chk("t5 gap holds idx", a_idx, 4);
      if (i == 7) chk("t5 gap valid", a_valid, 0);
    end
    chk("t5 no early word", a_data, 0);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      serial_in = (8'h3C >> i) & 1'b1;
      serial_valid = 1'b1;
      tick();
      if (i == 7) begin
        chk("t5 3C valid", a_valid, 1);
        chk("t5 3C data", a_data, 8'h3C);
      end
      serial_valid = 1'b0;
      tick();
    end
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) send_word(8'h77);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    chk("t5 pre-rst idx", a_idx, 5);
    chk("t5 pre-rst ovf", a_ovf, 1);
    rst = 1'b1;
    serial_in = 1'b1;
    serial_valid = 1'b1;
    tick();
    rst = 1'b0;
    serial_valid = 1'b0;
    chk("t5 rst idx", a_idx, 0);
    chk("t5 rst valid", a_valid, 0);
    chk("t5 rst data", a_data, 0);
    chk("t5 rst overflow", a_ovf, 0);
    chk("t5 rst drop_count", a_cnt, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      serial_in = (8'h96 >> i) & 1'b1;
      serial_valid = 1'b1;
      tick();
    end
    serial_valid = 1'b0;
    chk("t5 96 valid", a_valid, 1);
    chk("t5 96 data", a_data, 8'h96);

    // T6: counter saturation with CNT_W=2
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 9; k++) send_word(8'(k + 8'hC0));
    chk("t6 sat count", s_cnt, 3);
    chk("t6 sat overflow", s_ovf, 1);
    chk("t6 wide count", a_cnt, 5);
    chk("t6 head kept", s_data, 8'hC0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
